supersample_sched: RTL and testbench

- Sits directly after the chroma supersampling stage and ahead of colour conversion.
- Accepts one bundle per handshake: up to four 8x8 blocks plus a 4-bit block-valid mask and a channel tag.
- Serializes the bundle into a stream of single 8x8 blocks, one per accepted output beat, with valid/ready backpressure.
- Signals the end of each MCU (the end of a Cr bundle) to the downstream sequencer.

---
 rtl/supersample_sched_if.sv | 33 +++
 rtl/supersample_sched.sv | 96 +++++++++
 tb/tb_supersample_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/supersample_sched_if.sv
// Bundle-in / block-out handshake bundle for supersample_sched.
// slave is the scheduler's view, master is the upstream/downstream side.
interface supersample_sched_if #(
    parameter int unsigned PW  = 9,
    parameter int unsigned CHW = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [3:0]                  in_mask;
    logic [CHW-1:0]              in_ch;
    logic [7:0][7:0][PW-1:0]     in_blk_0;
    logic [7:0][7:0][PW-1:0]     in_blk_1;
    logic [7:0][7:0][PW-1:0]     in_blk_2;
    logic [7:0][7:0][PW-1:0]     in_blk_3;
    logic                        out_valid;
    logic                        out_ready;
    logic [7:0][7:0][PW-1:0]     out_blk;
    logic [CHW-1:0]              out_ch;
    logic [1:0]                  out_idx;
    logic                        out_last;
    logic                        mcu_done;
    logic                        busy;

    modport slave (
        input  in_valid, in_mask, in_ch, in_blk_0, in_blk_1, in_blk_2, in_blk_3, out_ready,
        output in_ready, out_valid, out_blk, out_ch, out_idx, out_last, mcu_done, busy
    );

    modport master (
        output in_valid, in_mask, in_ch, in_blk_0, in_blk_1, in_blk_2, in_blk_3, out_ready,
        input  in_ready, out_valid, out_blk, out_ch, out_idx, out_last, mcu_done, busy
    );
endinterface

// File: rtl/supersample_sched.sv
// Serializes a bundle of up to four 8x8 blocks into single-block beats,
// flagging the last block of each bundle and the end of each MCU (Cr bundle).
module supersample_sched #(
    parameter int unsigned PW  = 9,
    parameter int unsigned CHW = 2
) (
    input logic                clk,
    input logic                rst,
    supersample_sched_if.slave bus
);
    typedef logic [7:0][7:0][PW-1:0] blk_t;
    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    localparam logic [CHW-1:0] ChCr = CHW'(2);

    state_e         state_q, state_d;
    logic [3:0]     pend_q, pend_d;
    logic [CHW-1:0] ch_q, ch_d;
    blk_t           blk_q [4];
    blk_t           blk_d [4];
    logic           mcu_q, mcu_d;

    logic [1:0] idx;
    logic       one_left;
    logic       out_valid;
    logic       out_last;
    logic       in_ready;
    logic       in_xfer;
    logic       out_xfer;

    // Lowest pending block goes first; gaps in the mask cost no cycles.
    always_comb begin
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[k]) idx = 2'(k);
        end
    end

    assign one_left = (pend_q != 4'd0) && ((pend_q & (pend_q - 4'd1)) == 4'd0);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        ch_d      = ch_q;
        blk_d     = blk_q;
        mcu_d     = 1'b0;
        out_valid = (state_q == StDrain);
        out_last  = out_valid & one_left;
        // Accepting during the final beat lets the next bundle follow with no bubble.
        in_ready  = (state_q == StIdle) | (bus.out_ready & out_last);
        in_xfer   = bus.in_valid & in_ready;
        out_xfer  = out_valid & bus.out_ready;

        if (out_xfer) begin
            pend_d[idx] = 1'b0;
            mcu_d       = out_last & (ch_q == ChCr);
            if (out_last) state_d = StIdle;
        end

        if (in_xfer) begin
            blk_d[0] = bus.in_blk_0;
            blk_d[1] = bus.in_blk_1;
            blk_d[2] = bus.in_blk_2;
            blk_d[3] = bus.in_blk_3;
            pend_d   = bus.in_mask;
            ch_d     = bus.in_ch;
            // An empty mask is swallowed without producing any beat.
            state_d  = (bus.in_mask != 4'd0) ? StDrain : StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pend_q  <= 4'd0;
            ch_q    <= '0;
            mcu_q   <= 1'b0;
            for (int k = 0; k < 4; k++) blk_q[k] <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            mcu_q   <= mcu_d;
            blk_q   <= blk_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_idx   = idx;
    assign bus.out_ch    = ch_q;
    assign bus.out_blk   = blk_q[idx];
    assign bus.mcu_done  = mcu_q;
    assign bus.busy      = (state_q == StDrain);
endmodule

// File: tb/tb_supersample_sched.sv
// Randomized bench for supersample_sched: a bundle-level model expands each accepted
// bundle into expected beats, which a negedge monitor checks against the DUT.
module tb_supersample_sched;
    localparam int unsigned PW  = 9;
    localparam int unsigned CHW = 2;
    localparam int unsigned BW  = 64 * PW;

    typedef logic [7:0][7:0][PW-1:0] blk_t;
    typedef struct {
        blk_t     blk;
        logic [1:0] ch;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   rdy_pct = 100;
    beat_t q[$];
    logic  exp_mcu = 1'b0;

    supersample_sched_if #(.PW(PW), .CHW(CHW)) bus ();

    supersample_sched #(.PW(PW), .CHW(CHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) b[i][j] = PW'($urandom);
        return b;
    endfunction

    // Downstream readiness: 100 means always ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor and scoreboard: check first, then queue up any bundle accepted this cycle.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            exp_mcu = 1'b0;
        end else begin
            logic exp_rdy;
            chk("mcu_done", bus.mcu_done, exp_mcu);
            exp_mcu = 1'b0;
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("busy", bus.busy, q.size() != 0);
            if (q.size() == 0) exp_rdy = 1'b1;
            else exp_rdy = bus.out_ready && q[0].last;
            chk("in_ready", bus.in_ready, exp_rdy);
            if (bus.out_valid && q.size() != 0) begin
                chk("out_blk", bus.out_blk, q[0].blk);
                chk("out_ch", bus.out_ch, q[0].ch);
                chk("out_idx", bus.out_idx, q[0].idx);
                chk("out_last", bus.out_last, q[0].last);
                if (bus.out_ready) begin
                    exp_mcu = q[0].last && (q[0].ch == 2'd2);
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                blk_t blks [4];
                blks[0] = bus.in_blk_0;
                blks[1] = bus.in_blk_1;
                blks[2] = bus.in_blk_2;
                blks[3] = bus.in_blk_3;
                for (int k = 0; k < 4; k++) begin
                    if (bus.in_mask[k]) begin
                        beat_t b;
                        b.blk  = blks[k];
                        b.ch   = bus.in_ch;
                        b.idx  = 2'(k);
                        b.last = (bus.in_mask >> (k + 1)) == 4'd0;
                        q.push_back(b);
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] mask, input logic [1:0] ch);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_mask  = mask;
        bus.in_ch    = ch;
        bus.in_blk_0 = rand_blk();
        bus.in_blk_1 = rand_blk();
        bus.in_blk_2 = rand_blk();
        bus.in_blk_3 = rand_blk();
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at %0b want 1", bus.in_ready);
                break;
            end
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 || bus.out_valid) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: pending=%0d want 0", q.size());
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_mask  = 4'd0;
        bus.in_ch    = 2'd0;
        bus.in_blk_0 = '0;
        bus.in_blk_1 = '0;
        bus.in_blk_2 = '0;
        bus.in_blk_3 = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_mcu_done", bus.mcu_done, 1'b0);
        chk("rst_out_ch", bus.out_ch, 2'd0);
        chk("rst_out_idx", bus.out_idx, 2'd0);
        chk("rst_out_blk", bus.out_blk, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        @(posedge clk);
        #1;
        rdy_pct = 100;
        send(4'b0001, 2'd0);
        drain();
        send(4'b1111, 2'd1);
        drain();
        rdy_pct = 40;
        send(4'b1111, 2'd2);
        drain();
        rdy_pct = 100;
        send(4'b0101, 2'd0);
        send(4'b0000, 2'd1);
        send(4'b1000, 2'd2);
        drain();
        send(4'b1111, 2'd1);
        send(4'b1111, 2'd2);
        drain();
        send(4'b0110, 2'd3);
        drain();

        for (int i = 0; i < 150; i++) begin
            rdy_pct = (i < 75) ? 60 : 90;
            send(4'($urandom), 2'($urandom));
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_pct = 100;
        drain();

        // Asynchronous reset while block 1 of a full bundle is on the output.
        send(4'b1111, 2'd2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_out_last", bus.out_last, 1'b0);
        chk("mid_rst_mcu_done", bus.mcu_done, 1'b0);
        chk("mid_rst_out_idx", bus.out_idx, 2'd0);
        chk("mid_rst_out_ch", bus.out_ch, 2'd0);
        chk("mid_rst_out_blk", bus.out_blk, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_out_valid", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
